multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised control unit for the multicycle MIPS CPU. Sequences IF/ID/EXE/MEM/WB
//  and drives datapath enables. Adds what the fixed-timing control lacks:
//  - a req/ready memory handshake with timeout
//  - sticky HALT and ERR states
//  - a retired-instruction counter
//  - optional multi-cycle multiply
// PARAMETERS
//  OPCODE_W     6   opcode width; encodings below are zero-extended to OPCODE_W
//  MEM_TIMEOUT  15  max wait cycles per memory request before ERR (>=1)
//  CNT_W        32  retired-instruction counter width
//  MUL_LAT      4   multiply stall cycles (MULDIV_EN only, >=1)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  opcode     in   OPCODE_W  IR opcode; stable from ID until next IF
//  zero       in   1         ALU zero flag
//  mem_ready  in   1         memory accepted/completed current request
//  pc_wre     out  1         PC write enable
//  ir_wre     out  1         IR write enable
//  reg_wre    out  1         register file write enable
//  alu_src_b  out  1         1 = extended immediate, 0 = rt
//  mem_req    out  1         memory request (fetch or data)
//  mem_we     out  1         data write, valid with mem_req
//  m2reg      out  1         1 = write-back from memory, 0 = ALU
//  ext_sel    out  2         00 = shamt, 01 = zero-extend, 10 = sign-extend
//  reg_dst    out  2         00 = $31, 01 = rt, 10 = rd
//  pc_src     out  2         00 = PC+4, 01 = branch, 10 = rs (JR), 11 = jump target
//  alu_op     out  3         000 add, 001 sub, 010 slt, 011 sll, 100 or, 101 and, 111 mul
//  state      out  3         IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5 ERR=6 MUL=7
//  halted     out  1         state==HALT
//  err        out  1         state==ERR
//  instr_cnt  out  CNT_W     count of pc_wre pulses since reset; wraps
// BEHAVIOUR
//  Opcodes:
//   ADD 000000   SUB 000001   ADDI 000010  OR 000100   AND 000101
//   ORI 000110   SLL 011000   SLT 100110   SW 110000   LW 110001
//   BEQ 110100   J 111000     JR 111001    JAL 111010  HALT 111111
//   Any other opcode is illegal.
//  Reset:
//   - state=IF, wait counter=0, instr_cnt=0
//   - while reset=1, all enables and mem_req are forced 0
//  Outputs are combinational from state, opcode, zero and mem_ready.
//   Every enable not listed for a state is 0.
//  IF:
//   - mem_req=1, mem_we=0
//   - mem_ready=1 -> ir_wre=1, next state ID
//  ID:
//   - J: pc_wre=1, pc_src=11, next IF
//   - JR: pc_wre=1, pc_src=10, next IF
//   - JAL: pc_wre=1, pc_src=11, reg_wre=1, reg_dst=00, next IF
//   - HALT -> HALT; illegal -> ERR; otherwise -> EXE
//  EXE (alu_src_b, ext_sel, alu_op per opcode):
//   - BEQ: alu_op=001; pc_wre=1; pc_src = zero ? 01 : 00; next IF
//   - LW/SW: alu_op=000, ext_sel=10; next MEM
//   - Other legal opcodes: next WB
//  MEM:
//   - mem_req=1, mem_we = (opcode==SW)
//   - On mem_ready: SW -> pc_wre=1, next IF; LW -> next WB
//  WB:
//   - reg_wre=1, pc_wre=1, next IF
//   - reg_dst = 10 for R-type, 01 otherwise
//   - m2reg = (opcode==LW)
//  Wait counter:
//   - cleared on entry to IF or MEM, and whenever mem_ready=1
//   - increments each cycle mem_req=1 && mem_ready=0
//   - reaching MEM_TIMEOUT with mem_ready=0 -> next ERR, no enables that cycle
//   - mem_ready=1 on the timeout cycle wins over the timeout
//  HALT and ERR are absorbing until reset; no enables and no mem_req.
//  instr_cnt increments on every cycle with pc_wre=1; all-ones wraps to 0.
//  Reset mid-instruction (e.g. during MEM) aborts: no write is issued; next cycle is IF.
// CONFIGURATION
//  MULTICYCLE_MULDIV_EN defined:
//   - opcode MUL 001000 is legal: EXE -> MUL state
//   - MUL holds alu_op=111 for MUL_LAT cycles (own counter), then -> WB, reg_dst=10
//  MULTICYCLE_MULDIV_EN undefined:
//   - 001000 is illegal (ID -> ERR)
//   - state value 7 is unreachable
// TESTING
//  1. ADD, mem_ready tied 1 -> IF,ID,EXE,WB; reg_wre=1 and reg_dst=10 in WB; instr_cnt=1.
//  2. LW, mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB with m2reg=1.
//  3. BEQ, zero=1 -> pc_src=01 in EXE; then BEQ, zero=0 -> pc_src=00; 3 cycles each.
//  4. Fetch with mem_ready held 0 -> ERR entered after 15 wait cycles; err=1 until reset.
//  5. Opcode 101010 -> ERR from ID. HALT -> halted=1; instr_cnt frozen.
//  6. Reset asserted in MEM of SW -> mem_we never 1; state=IF next cycle.
//     With MULDIV_EN: MUL takes 4+4 cycles and alu_op=111 in MUL.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/datapath bundle for the multicycle MIPS control unit.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_wre;
  logic                ir_wre;
  logic                reg_wre;
  logic                alu_src_b;
  logic                mem_req;
  logic                mem_we;
  logic                m2reg;
  logic [1:0]          ext_sel;
  logic [1:0]          reg_dst;
  logic [1:0]          pc_src;
  logic [2:0]          alu_op;
  logic [2:0]          state;
  logic                halted;
  logic                err;
  logic [CNT_W-1:0]    instr_cnt;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_wre, ir_wre, reg_wre, alu_src_b, mem_req, mem_we, m2reg,
           ext_sel, reg_dst, pc_src, alu_op, state, halted, err, instr_cnt
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_wre, ir_wre, reg_wre, alu_src_b, mem_req, mem_we, m2reg,
           ext_sel, reg_dst, pc_src, alu_op, state, halted, err, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory handshake timeout, sticky HALT/ERR and retire counter.
// Define MULTICYCLE_MULDIV_EN to enable the multi-cycle MUL opcode and state.
module multicycle_ctrl_fsm #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MUL_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus_io
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OpOr   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OpAnd  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OpOri  = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OpSll  = OPCODE_W'(6'b011000);
  localparam logic [OPCODE_W-1:0] OpSlt  = OPCODE_W'(6'b100110);
  localparam logic [OPCODE_W-1:0] OpSw   = OPCODE_W'(6'b110000);
  localparam logic [OPCODE_W-1:0] OpLw   = OPCODE_W'(6'b110001);
  localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(6'b110100);
  localparam logic [OPCODE_W-1:0] OpJ    = OPCODE_W'(6'b111000);
  localparam logic [OPCODE_W-1:0] OpJr   = OPCODE_W'(6'b111001);
  localparam logic [OPCODE_W-1:0] OpJal  = OPCODE_W'(6'b111010);
  localparam logic [OPCODE_W-1:0] OpHalt = OPCODE_W'(6'b111111);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5,
    StErr  = 3'd6,
    StMul  = 3'd7
  } state_e;

  if (MEM_TIMEOUT == 0 || MUL_LAT == 0) begin : g_bad_param
    $error("multicycle_ctrl_fsm: MEM_TIMEOUT and MUL_LAT must be >= 1");
  end

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_hit;

  logic               legal, r_type, dec_src_b;
  logic [1:0]         dec_ext;
  logic [2:0]         dec_alu;
  logic               is_lw, is_sw, is_beq, is_j, is_jr, is_jal, is_halt;

  logic               pc_wre, ir_wre, reg_wre, alu_src_b, mem_req, mem_we, m2reg;
  logic [1:0]         ext_sel, reg_dst, pc_src;
  logic [2:0]         alu_op;

  assign is_lw   = (bus_io.opcode == OpLw);
  assign is_sw   = (bus_io.opcode == OpSw);
  assign is_beq  = (bus_io.opcode == OpBeq);
  assign is_j    = (bus_io.opcode == OpJ);
  assign is_jr   = (bus_io.opcode == OpJr);
  assign is_jal  = (bus_io.opcode == OpJal);
  assign is_halt = (bus_io.opcode == OpHalt);

`ifdef MULTICYCLE_MULDIV_EN
  localparam logic [OPCODE_W-1:0] OpMul = OPCODE_W'(6'b001000);
  localparam int unsigned MulW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [MulW-1:0] mul_q, mul_d;
  logic            mul_done, is_mul;

  assign is_mul   = (bus_io.opcode == OpMul);
  assign mul_done = (mul_q == MulW'(MUL_LAT - 1));

  always_comb begin
    mul_d = '0;
    if (state_q == StMul && !mul_done) mul_d = mul_q + MulW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) mul_q <= '0;
    else       mul_q <= mul_d;
  end
`endif

  // Per-opcode datapath selects, consumed in EXE (and reg_dst in WB).
  always_comb begin
    legal     = 1'b1;
    r_type    = 1'b0;
    dec_src_b = 1'b0;
    dec_ext   = 2'b10;
    dec_alu   = 3'b000;
    case (bus_io.opcode)
      OpAdd:  r_type = 1'b1;
      OpSub:  begin r_type = 1'b1; dec_alu = 3'b001; end
      OpAddi: dec_src_b = 1'b1;
      OpOr:   begin r_type = 1'b1; dec_alu = 3'b100; end
      OpAnd:  begin r_type = 1'b1; dec_alu = 3'b101; end
      OpOri:  begin dec_src_b = 1'b1; dec_ext = 2'b01; dec_alu = 3'b100; end
      OpSll:  begin r_type = 1'b1; dec_src_b = 1'b1; dec_ext = 2'b00; dec_alu = 3'b011; end
      OpSlt:  begin r_type = 1'b1; dec_alu = 3'b010; end
      OpSw, OpLw: dec_src_b = 1'b1;
      OpBeq:  dec_alu = 3'b001;
      OpJ, OpJr, OpJal, OpHalt: ;
`ifdef MULTICYCLE_MULDIV_EN
      OpMul:  begin r_type = 1'b1; dec_alu = 3'b111; end
`endif
      default: legal = 1'b0;
    endcase
  end

  assign wait_hit = (wait_q == WaitW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    alu_src_b = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    m2reg     = 1'b0;
    ext_sel   = 2'b00;
    reg_dst   = 2'b00;
    pc_src    = 2'b00;
    alu_op    = 3'b000;
    unique case (state_q)
      StIf: begin
        mem_req = 1'b1;
        if (bus_io.mem_ready) begin
          ir_wre  = 1'b1;
          state_d = StId;
        end else if (wait_hit) begin
          state_d = StErr;
        end
      end
      StId: begin
        if (!legal) begin
          state_d = StErr;
        end else if (is_j || is_jal) begin
          pc_wre  = 1'b1;
          pc_src  = 2'b11;
          reg_wre = is_jal;
          state_d = StIf;
        end else if (is_jr) begin
          pc_wre  = 1'b1;
          pc_src  = 2'b10;
          state_d = StIf;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        alu_src_b = dec_src_b;
        ext_sel   = dec_ext;
        alu_op    = dec_alu;
        if (is_beq) begin
          pc_wre  = 1'b1;
          pc_src  = bus_io.zero ? 2'b01 : 2'b00;
          state_d = StIf;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
`ifdef MULTICYCLE_MULDIV_EN
        end else if (is_mul) begin
          state_d = StMul;
`endif
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (bus_io.mem_ready) begin
          pc_wre  = is_sw;
          state_d = is_sw ? StIf : StWb;
        end else if (wait_hit) begin
          state_d = StErr;
        end
      end
      StWb: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        reg_dst = r_type ? 2'b10 : 2'b01;
        m2reg   = is_lw;
        state_d = StIf;
      end
      StHalt, StErr: ;
      StMul: begin
`ifdef MULTICYCLE_MULDIV_EN
        alu_op = 3'b111;
        if (mul_done) state_d = StWb;
`else
        state_d = StErr;
`endif
      end
    endcase
    // Reset suppresses every side effect of the aborted instruction.
    if (reset) begin
      pc_wre  = 1'b0;
      ir_wre  = 1'b0;
      reg_wre = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // Ready always clears the count, so ready on the timeout cycle wins.
  always_comb begin
    wait_d = '0;
    if (mem_req && !bus_io.mem_ready && !wait_hit) wait_d = wait_q + WaitW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_wre) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIf;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.pc_wre    = pc_wre;
  assign bus_io.ir_wre    = ir_wre;
  assign bus_io.reg_wre   = reg_wre;
  assign bus_io.alu_src_b = alu_src_b;
  assign bus_io.mem_req   = mem_req;
  assign bus_io.mem_we    = mem_we;
  assign bus_io.m2reg     = m2reg;
  assign bus_io.ext_sel   = ext_sel;
  assign bus_io.reg_dst   = reg_dst;
  assign bus_io.pc_src    = pc_src;
  assign bus_io.alu_op    = alu_op;
  assign bus_io.state     = state_q;
  assign bus_io.halted    = (state_q == StHalt);
  assign bus_io.err       = (state_q == StErr);
  assign bus_io.instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction table checked cycle by cycle through a queue,
// then hand-written sequences for timeouts, HALT/ERR, reset abort and MUL.
module tb_multicycle_ctrl_fsm;
  localparam int unsigned OpW  = 6;
  localparam int unsigned CntW = 32;
  localparam logic [2:0] SIf = 3'd0, SId = 3'd1, SExe = 3'd2, SMem = 3'd3, SWb = 3'd4;
  localparam logic [2:0] SHalt = 3'd5, SErr = 3'd6, SMul = 3'd7;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SW = 6'b110000, OP_LW = 6'b110001;
  localparam logic [5:0] OP_JAL = 6'b111010, OP_HALT = 6'b111111;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.OPCODE_W(OpW), .CNT_W(CntW)) bus ();

  multicycle_ctrl_fsm #(
    .OPCODE_W(OpW), .MEM_TIMEOUT(15), .CNT_W(CntW), .MUL_LAT(4)
  ) dut (
    .clk(clk), .reset(reset), .bus_io(bus)
  );

  // path: octal digits, first state in the least-significant digit. ext: {care, value}.
  typedef struct {
    logic [5:0]  op;
    logic        zero;
    int          mwait;
    logic [23:0] path;
    int          n;
    logic [2:0]  alu;
    logic        srcb;
    logic [2:0]  ext;
    logic [1:0]  dst;
    logic        m2r;
    logic [1:0]  pcs;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       rdy, first;
    logic       pc_wre, ir_wre, reg_wre, mem_req, mem_we;
    logic [2:0] alu;
    logic       srcb;
    logic [2:0] ext;
    logic [1:0] dst;
    logic       m2r;
    logic [1:0] pcs;
  } exp_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t e;
  int   n_tests, n_fail, exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [5:0] op, input logic z);
    @(negedge clk);
    reset         = rst;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    bus.zero      = z;
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic z, input int mw,
                              input logic [23:0] p, input int n, input logic [2:0] alu,
                              input logic sb_, input logic [2:0] ext, input logic [1:0] dst,
                              input logic m2r, input logic [1:0] pcs);
    vec_t v;
    v.op = op; v.zero = z; v.mwait = mw; v.path = p; v.n = n; v.alu = alu;
    v.srcb = sb_; v.ext = ext; v.dst = dst; v.m2r = m2r; v.pcs = pcs;
    return v;
  endfunction

  // Expected per-cycle behaviour of one instruction; the final cycle always retires it.
  task automatic push_vec(input vec_t v);
    int mi = 0;
    for (int i = 0; i < v.n; i++) begin
      exp_t x;
      x.st      = v.path[3*i +: 3];
      x.rdy     = !(x.st == SMem && mi < v.mwait);
      if (x.st == SMem) mi++;
      x.first   = (i == 0);
      x.ir_wre  = (x.st == SIf);
      x.pc_wre  = (i == v.n - 1);
      x.reg_wre = (x.st == SWb) || (x.st == SId && v.op == OP_JAL);
      x.mem_req = (x.st == SIf) || (x.st == SMem);
      x.mem_we  = (x.st == SMem) && (v.op == OP_SW);
      x.alu = v.alu; x.srcb = v.srcb; x.ext = v.ext;
      x.dst = v.dst; x.m2r = v.m2r; x.pcs = v.pcs;
      sb.push_back(x);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, OP_ADD, 1'b0);
    exp_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = 0;
    reset = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_ADD; bus.zero = 1'b0;

    vecs[0]  = mk(6'b000000, 0, 0, 24'o4210,     4, 3'b000, 0, 3'b000, 2'b10, 0, 2'b00);
    vecs[1]  = mk(6'b000001, 0, 0, 24'o4210,     4, 3'b001, 0, 3'b000, 2'b10, 0, 2'b00);
    vecs[2]  = mk(6'b000010, 0, 0, 24'o4210,     4, 3'b000, 1, 3'b110, 2'b01, 0, 2'b00);
    vecs[3]  = mk(6'b000100, 0, 0, 24'o4210,     4, 3'b100, 0, 3'b000, 2'b10, 0, 2'b00);
    vecs[4]  = mk(6'b000101, 0, 0, 24'o4210,     4, 3'b101, 0, 3'b000, 2'b10, 0, 2'b00);
    vecs[5]  = mk(6'b000110, 0, 0, 24'o4210,     4, 3'b100, 1, 3'b101, 2'b01, 0, 2'b00);
    vecs[6]  = mk(6'b011000, 0, 0, 24'o4210,     4, 3'b011, 1, 3'b100, 2'b10, 0, 2'b00);
    vecs[7]  = mk(6'b100110, 0, 0, 24'o4210,     4, 3'b010, 0, 3'b000, 2'b10, 0, 2'b00);
    vecs[8]  = mk(6'b110001, 0, 3, 24'o43333210, 8, 3'b000, 1, 3'b110, 2'b01, 1, 2'b00);
    vecs[9]  = mk(6'b110000, 0, 1, 24'o33210,    5, 3'b000, 1, 3'b110, 2'b00, 0, 2'b00);
    vecs[10] = mk(6'b110100, 1, 0, 24'o210,      3, 3'b001, 0, 3'b000, 2'b00, 0, 2'b01);
    vecs[11] = mk(6'b110100, 0, 0, 24'o210,      3, 3'b001, 0, 3'b000, 2'b00, 0, 2'b00);
    vecs[12] = mk(6'b111000, 0, 0, 24'o10,       2, 3'b000, 0, 3'b000, 2'b00, 0, 2'b11);
    vecs[13] = mk(6'b111001, 0, 0, 24'o10,       2, 3'b000, 0, 3'b000, 2'b00, 0, 2'b10);
    vecs[14] = mk(6'b111010, 0, 0, 24'o10,       2, 3'b000, 0, 3'b000, 2'b00, 0, 2'b11);
    vecs[15] = mk(6'b110001, 0, 0, 24'o43210,    5, 3'b000, 1, 3'b110, 2'b01, 1, 2'b00);

    // Reset state: enables forced low even with mem_ready high in IF.
    drive(1'b1, 1'b1, OP_ADD, 1'b0);
    drive(1'b1, 1'b1, OP_ADD, 1'b0);
    check("rst.state", bus.state, SIf);
    check("rst.mem_req", bus.mem_req, 0);
    check("rst.ir_wre", bus.ir_wre, 0);
    check("rst.instr_cnt", bus.instr_cnt, 0);

    for (int k = 0; k < NV; k++) begin
      push_vec(vecs[k]);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        drive(1'b0, e.rdy, vecs[k].op, vecs[k].zero);
        check($sformatf("v%0d.state", k), bus.state, e.st);
        check($sformatf("v%0d.pc_wre", k), bus.pc_wre, e.pc_wre);
        check($sformatf("v%0d.ir_wre", k), bus.ir_wre, e.ir_wre);
        check($sformatf("v%0d.reg_wre", k), bus.reg_wre, e.reg_wre);
        check($sformatf("v%0d.mem_req", k), bus.mem_req, e.mem_req);
        check($sformatf("v%0d.mem_we", k), bus.mem_we, e.mem_we);
        if (e.first) check($sformatf("v%0d.instr_cnt", k), bus.instr_cnt, exp_cnt);
        if (e.st == SExe) begin
          check($sformatf("v%0d.alu_op", k), bus.alu_op, e.alu);
          check($sformatf("v%0d.alu_src_b", k), bus.alu_src_b, e.srcb);
          if (e.ext[2]) check($sformatf("v%0d.ext_sel", k), bus.ext_sel, e.ext[1:0]);
        end
        if (e.pc_wre) check($sformatf("v%0d.pc_src", k), bus.pc_src, e.pcs);
        if (e.reg_wre) check($sformatf("v%0d.reg_dst", k), bus.reg_dst, e.dst);
        if (e.st == SWb) check($sformatf("v%0d.m2reg", k), bus.m2reg, e.m2r);
      end
      exp_cnt++;
    end

    // HALT is absorbing and freezes the retire counter.
    drive(1'b0, 1'b1, OP_HALT, 1'b0);
    check("halt.if_cnt", bus.instr_cnt, exp_cnt);
    drive(1'b0, 1'b1, OP_HALT, 1'b0);
    check("halt.id", bus.state, SId);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, OP_HALT, 1'b0);
      check("halt.state", bus.state, SHalt);
      check("halt.halted", bus.halted, 1);
      check("halt.mem_req", bus.mem_req, 0);
      check("halt.instr_cnt", bus.instr_cnt, exp_cnt);
    end
    do_reset();

    // Illegal opcode traps from ID and stays in ERR.
    drive(1'b0, 1'b1, 6'b101010, 1'b0);
    check("ill.instr_cnt", bus.instr_cnt, 0);
    drive(1'b0, 1'b1, 6'b101010, 1'b0);
    check("ill.id", bus.state, SId);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 6'b101010, 1'b0);
      check("ill.err", bus.err, 1);
      check("ill.state", bus.state, SErr);
      check("ill.mem_req", bus.mem_req, 0);
    end
    do_reset();

    // MUL opcode: multi-cycle when enabled, illegal otherwise.
    drive(1'b0, 1'b1, 6'b001000, 1'b0);
    drive(1'b0, 1'b1, 6'b001000, 1'b0);
`ifdef MULTICYCLE_MULDIV_EN
    drive(1'b0, 1'b1, 6'b001000, 1'b0);
    check("mul.exe", bus.state, SExe);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 6'b001000, 1'b0);
      check("mul.state", bus.state, SMul);
      check("mul.alu_op", bus.alu_op, 3'b111);
    end
    drive(1'b0, 1'b1, 6'b001000, 1'b0);
    check("mul.wb", bus.state, SWb);
    check("mul.reg_dst", bus.reg_dst, 2'b10);
`else
    drive(1'b0, 1'b1, 6'b001000, 1'b0);
    check("mul.illegal", bus.state, SErr);
`endif
    do_reset();

    // Fetch timeout: 15 waiting cycles in IF, then ERR.
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, OP_ADD, 1'b0);
      check("fto.state", bus.state, SIf);
      check("fto.mem_req", bus.mem_req, 1);
    end
    drive(1'b0, 1'b0, OP_ADD, 1'b0);
    check("fto.err", bus.err, 1);
    drive(1'b0, 1'b1, OP_ADD, 1'b0);
    check("fto.sticky", bus.err, 1);
    check("fto.ir_wre", bus.ir_wre, 0);
    do_reset();

    // Ready on the timeout cycle wins: LW completes after 14 stalls.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, OP_LW, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, OP_LW, 1'b0);
      check("mrw.state", bus.state, SMem);
    end
    drive(1'b0, 1'b1, OP_LW, 1'b0);
    check("mrw.last", bus.state, SMem);
    drive(1'b0, 1'b1, OP_LW, 1'b0);
    check("mrw.wb", bus.state, SWb);
    check("mrw.m2reg", bus.m2reg, 1);
    exp_cnt++;

    // Data timeout: SW never acknowledged, no write-back, then ERR.
    drive(1'b0, 1'b1, OP_SW, 1'b0);
    check("mto.instr_cnt", bus.instr_cnt, exp_cnt);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, OP_SW, 1'b0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, OP_SW, 1'b0);
      check("mto.state", bus.state, SMem);
      check("mto.pc_wre", bus.pc_wre, 0);
    end
    drive(1'b0, 1'b0, OP_SW, 1'b0);
    check("mto.err", bus.state, SErr);
    do_reset();

    // Reset landing in MEM of SW aborts the store.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, OP_SW, 1'b0);
    drive(1'b1, 1'b1, OP_SW, 1'b0);
    check("rmem.state", bus.state, SMem);
    check("rmem.mem_we", bus.mem_we, 0);
    check("rmem.mem_req", bus.mem_req, 0);
    check("rmem.pc_wre", bus.pc_wre, 0);
    drive(1'b0, 1'b1, OP_SW, 1'b0);
    check("rmem.if", bus.state, SIf);
    check("rmem.instr_cnt", bus.instr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
